snake_body_engine: RTL and testbench
====================================

SNAKE_BODY_ENGINE -- requirements
Module: snake_body_engine

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 32, giving the maximum snake length in segments (power of two).
REQ-002 The block SHALL have parameter START_X, default 80, giving the head x after reset.
REQ-003 The block SHALL have parameter START_Y, default 60, giving the head y after reset.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-005 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port tick, input, 1 bit, a one-cycle step request from snake_control.
REQ-007 The block SHALL have port dir, input, 2 bits, encoded 00 right, 01 up, 10 left, 11 down.
REQ-008 The block SHALL have port grow, input, 1 bit, a one-cycle "food eaten" pulse.
REQ-009 The block SHALL have ports x, y and colour, outputs of 8, 7 and 3 bits, forming the vga_adapter pixel write (160x120 grid, RGB 1 bit each).
REQ-010 The block SHALL have port plot, output, 1 bit, the vga_adapter write strobe.
REQ-011 The block SHALL have ports busy (1 bit), dead (1 bit) and length ($clog2(MAX_LEN)+1 bits), all outputs.

Function
REQ-012 States SHALL be INIT, IDLE, CALC, SCAN, ERASE, DRAW and DEAD.
REQ-013 INIT SHALL last one cycle, plot the head at (START_X,START_Y) in green (010), then go to IDLE.
REQ-014 IDLE with tick=1 SHALL go to CALC; tick in any other state SHALL be dropped.
REQ-015 CALC SHALL register the next head as old head +/-1 on one axis per the effective direction.
REQ-016 A dir equal to the reverse of the current direction SHALL be ignored, keeping the current direction; length 1 is exempt.
REQ-017 A next head with x>159 or y>119 (including 0-1 wrap) SHALL go to DEAD instead of SCAN.
REQ-018 SCAN SHALL take exactly `length` cycles and compare one stored segment per cycle with the next head.
REQ-019 In SCAN, a tail match SHALL be ignored unless grow is pending; any other match SHALL go to DEAD.
REQ-020 ERASE SHALL last one cycle: with no grow pending it plots the tail in black (000) and retires it; with grow pending, plot=0 and length increments.
REQ-021 DRAW SHALL last one cycle, plot the new head in green, push it into the body buffer, then return to IDLE.
REQ-022 busy SHALL be 1 in INIT and from CALC through DRAW inclusive, and 0 in IDLE and DEAD.
REQ-023 grow SHALL latch in any state and clear in ERASE; at length=MAX_LEN it SHALL be discarded without a length increment.
REQ-024 On entry to DEAD, the block SHALL plot the old head in red (100) for one cycle, then hold dead=1 and plot=0 until reset.
REQ-025 plot SHALL be 0 in every cycle not named above; x, y and colour are don't-care when plot=0.

Reset
REQ-026 reset_n low SHALL asynchronously force state INIT, plot=0, busy=0, dead=0, length=1, direction right, grow latch clear and head (START_X,START_Y).
REQ-027 Reset mid-operation SHALL abandon the step with no further plot; the screen is cleared externally by the vga_adapter reset.

Configuration
REQ-028 With SNAKE_SELF_COLLIDE_EN defined, SCAN SHALL run as in REQ-018 and REQ-019.
REQ-029 Without SNAKE_SELF_COLLIDE_EN, SCAN SHALL be omitted: CALC goes straight to ERASE and self-overlap is never fatal.
REQ-030 Step latency from tick to the DRAW plot SHALL be 3 cycles without the macro and 3+length cycles with it.

Structure
REQ-031 Package snake_pkg SHALL hold the direction encoding, the colour constants (BLACK, GREEN, RED), the state enum and the coordinate widths (8/7).
REQ-032 Sub-module snake_ring SHALL be a MAX_LEN-deep circular position buffer with head/tail pointers, push, pop and an indexed read port for SCAN.

Verification
REQ-033 Release reset -> one plot (80,60,010) with busy=1, then busy=0 and length=1.
REQ-034 tick with dir=00 -> plot (80,60,000), then plot (81,60,010); busy low 4 cycles after tick without the macro.
REQ-035 grow pulse then tick -> no erase plot, draw (81,60,010), length=2.
REQ-036 Head at (159,60), dir=00, tick -> red plot at (159,60), dead=1, and later ticks produce no plot.
REQ-037 length 2 moving right, dir=10, tick -> direction kept, head goes to x+1.
REQ-038 With the macro, a length-5 snake steered into itself -> dead=1 after 1+5 cycles of CALC/SCAN and a red plot at the old head.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine: directions, colours, FSM states
// and the 160x120 grid coordinate widths.
package snake_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int POS_W = X_W + Y_W;

  localparam logic [X_W-1:0] X_MAX = 8'd159;
  localparam logic [Y_W-1:0] Y_MAX = 7'd119;

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    CALC,
    SCAN,
    ERASE,
    DRAW,
    DEAD
  } state_e;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_ring.sv
// Circular buffer of packed {x,y} body segments, oldest (tail) first.
// Memory has a registered read addressed as an offset from the tail.
module snake_ring
  import snake_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = POS_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [PW-1:0] tail_ptr_q, tail_ptr_d;
  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  rd_data_q;

  always_comb begin
    head_ptr_d = push ? head_ptr_q + PW'(1) : head_ptr_q;
    tail_ptr_d = pop  ? tail_ptr_q + PW'(1) : tail_ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
    end
  end

  // Storage carries no reset so it maps onto block RAM; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[head_ptr_q] <= push_data;
    end
    rd_data_q <= mem[tail_ptr_q + rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/snake_body_engine.sv
// Snake movement engine: steps the head on tick, erases the tail / draws the head
// through the vga_adapter pixel port. Define SNAKE_SELF_COLLIDE_EN to add body collision.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int START_X = 80,
  parameter int START_Y = 60
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tick,
  input  logic [1:0]                dir,
  input  logic                      grow,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [2:0]                colour,
  output logic                      plot,
  output logic                      busy,
  output logic                      dead,
  output logic [$clog2(MAX_LEN):0]  length
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;

  state_e         state_q, state_d;
  logic [X_W-1:0] head_x_q, head_x_d, next_x_q, next_x_d, x_q, x_d, cand_x;
  logic [Y_W-1:0] head_y_q, head_y_d, next_y_q, next_y_d, y_q, y_d, cand_y;
  logic [1:0]     dir_q, dir_d, eff_dir;
  logic           grow_q, grow_d, grow_eff;
  logic [LW-1:0]  len_q, len_d;
  logic [2:0]     colour_q, colour_d;
  logic           plot_q, plot_d, busy_q, busy_d, dead_q, dead_d;

  logic             push, pop;
  logic [POS_W-1:0] push_data, rd_data;
  logic [PW-1:0]    rd_idx;

`ifdef SNAKE_SELF_COLLIDE_EN
  logic [PW-1:0] scan_idx_q, scan_idx_d;
  logic          hit_q, hit_d, seg_match;
`endif

  snake_ring #(
    .DEPTH (MAX_LEN),
    .W     (POS_W)
  ) u_ring (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  // A full-length snake discards food instead of growing.
  assign grow_eff = grow_q && (len_q != LW'(MAX_LEN));

  always_comb begin
    eff_dir = dir;
    if (dir == reverse_dir(dir_q) && len_q != LW'(1)) begin
      eff_dir = dir_q;
    end
    cand_x = head_x_q;
    cand_y = head_y_q;
    case (eff_dir)
      DIR_RIGHT: cand_x = head_x_q + 8'd1;
      DIR_UP:    cand_y = head_y_q - 7'd1;
      DIR_LEFT:  cand_x = head_x_q - 8'd1;
      DIR_DOWN:  cand_y = head_y_q + 7'd1;
      default:   cand_x = head_x_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    head_x_d  = head_x_q;
    head_y_d  = head_y_q;
    next_x_d  = next_x_q;
    next_y_d  = next_y_q;
    dir_d     = dir_q;
    grow_d    = grow_q | grow;
    len_d     = len_q;
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    busy_d    = 1'b0;
    dead_d    = 1'b0;
    push      = 1'b0;
    push_data = {next_x_q, next_y_q};
    pop       = 1'b0;
    rd_idx    = '0;
`ifdef SNAKE_SELF_COLLIDE_EN
    scan_idx_d = scan_idx_q;
    hit_d      = hit_q;
    seg_match  = 1'b0;
`endif
    case (state_q)
      INIT: begin
        busy_d    = 1'b1;
        plot_d    = 1'b1;
        x_d       = head_x_q;
        y_d       = head_y_q;
        colour_d  = GREEN;
        push      = 1'b1;
        push_data = {head_x_q, head_y_q};
        state_d   = IDLE;
      end
      IDLE: begin
        if (tick) state_d = CALC;
      end
      CALC: begin
        busy_d   = 1'b1;
        dir_d    = eff_dir;
        next_x_d = cand_x;
        next_y_d = cand_y;
        // Unsigned compare also catches 0-1 wrapping to the top of the range.
        if (cand_x > X_MAX || cand_y > Y_MAX) begin
          state_d = DEAD;
        end else begin
`ifdef SNAKE_SELF_COLLIDE_EN
          state_d    = SCAN;
          scan_idx_d = '0;
          hit_d      = 1'b0;
`else
          state_d = ERASE;
`endif
        end
      end
`ifdef SNAKE_SELF_COLLIDE_EN
      SCAN: begin
        busy_d    = 1'b1;
        // Index 0 is the tail, which vacates this step unless we are growing.
        seg_match = (rd_data == {next_x_q, next_y_q}) && (scan_idx_q != '0 || grow_eff);
        hit_d     = hit_q | seg_match;
        if (({1'b0, scan_idx_q} + LW'(1)) < len_q) begin
          scan_idx_d = scan_idx_q + PW'(1);
          rd_idx     = scan_idx_q + PW'(1);
        end else begin
          state_d = (hit_q || seg_match) ? DEAD : ERASE;
        end
      end
`endif
      ERASE: begin
        busy_d  = 1'b1;
        grow_d  = grow;
        state_d = DRAW;
        if (grow_eff) begin
          len_d = len_q + LW'(1);
        end else begin
          plot_d   = 1'b1;
          x_d      = rd_data[POS_W-1:Y_W];
          y_d      = rd_data[Y_W-1:0];
          colour_d = BLACK;
          pop      = 1'b1;
        end
      end
      DRAW: begin
        busy_d   = 1'b1;
        plot_d   = 1'b1;
        x_d      = next_x_q;
        y_d      = next_y_q;
        colour_d = GREEN;
        push     = 1'b1;
        head_x_d = next_x_q;
        head_y_d = next_y_q;
        state_d  = IDLE;
      end
      DEAD: begin
        dead_d = 1'b1;
        if (!dead_q) begin
          plot_d   = 1'b1;
          x_d      = head_x_q;
          y_d      = head_y_q;
          colour_d = RED;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      head_x_q <= X_W'(START_X);
      head_y_q <= Y_W'(START_Y);
      next_x_q <= '0;
      next_y_q <= '0;
      dir_q    <= DIR_RIGHT;
      grow_q   <= 1'b0;
      len_q    <= LW'(1);
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= BLACK;
      busy_q   <= 1'b0;
      dead_q   <= 1'b0;
`ifdef SNAKE_SELF_COLLIDE_EN
      scan_idx_q <= '0;
      hit_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      next_x_q <= next_x_d;
      next_y_q <= next_y_d;
      dir_q    <= dir_d;
      grow_q   <= grow_d;
      len_q    <= len_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      busy_q   <= busy_d;
      dead_q   <= dead_d;
`ifdef SNAKE_SELF_COLLIDE_EN
      scan_idx_q <= scan_idx_d;
      hit_q      <= hit_d;
`endif
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign dead   = dead_q;
  assign length = len_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine with a plot scoreboard and a small snake model.
module tb_snake_body_engine;

  localparam int MAXL = 8;
`ifdef SNAKE_SELF_COLLIDE_EN
  localparam bit SELF_COLLIDE = 1'b1;
`else
  localparam bit SELF_COLLIDE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       grow = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, dead;
  logic [3:0] length;

  int checks = 0;
  int failures = 0;

  logic [17:0] exp_q[$];
  logic [14:0] body[$];
  logic [17:0] mon_e;
  int          mx, my, mlen;
  logic [1:0]  mdir;
  bit          mgrow, mdead;

  snake_body_engine #(
    .MAX_LEN (MAXL),
    .START_X (80),
    .START_Y (60)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .dir     (dir),
    .grow    (grow),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .dead    (dead),
    .length  (length)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every plot must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (plot) begin
      check("plot_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("plot_xyc", {14'd0, x, y, colour}, {14'd0, mon_e});
        $display("plot x=%0d y=%0d colour=%03b", x, y, colour);
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    tick = 1'b0;
    grow = 1'b0;
    dir = 2'b00;
    @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_dead", dead, 0);
    check("rst_length", length, 1);
    check("rst_queue", exp_q.size(), 0);
    mx = 80; my = 60; mdir = 2'b00; mlen = 1; mgrow = 0; mdead = 0;
    body.delete();
    body.push_back({8'd80, 7'd60});
    exp_q.push_back({8'd80, 7'd60, 3'b010});
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("init_busy", busy, 1);
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("init_length", length, 1);
    @(posedge clk); #1;
    check("init_drained", exp_q.size(), 0);
  endtask

  task automatic do_step(input logic [1:0] d, input bit g, input bit spam);
    logic [1:0] ed;
    int         nx, ny, exp_k, kl;
    bit         hit, geff;
    if (g) begin
      grow = 1'b1;
      @(posedge clk); #1;
      grow = 1'b0;
      mgrow = 1;
    end
    if (mdead) begin
      exp_k = 1;
    end else begin
      ed = d;
      if (mlen > 1 && d == (mdir ^ 2'b10)) ed = mdir;
      nx = mx; ny = my;
      case (ed)
        2'b00: nx = mx + 1;
        2'b01: ny = my - 1;
        2'b10: nx = mx - 1;
        default: ny = my + 1;
      endcase
      geff = mgrow && (mlen < MAXL);
      if (nx < 0 || nx > 159 || ny < 0 || ny > 119) begin
        exp_k = 2;
        exp_q.push_back({8'(mx), 7'(my), 3'b100});
        mdead = 1;
      end else begin
        hit = 0;
        if (SELF_COLLIDE) begin
          for (int i = 0; i < body.size(); i++) begin
            if (body[i] == {8'(nx), 7'(ny)} && (i != 0 || geff)) hit = 1;
          end
        end
        if (hit) begin
          exp_k = 2 + mlen;
          exp_q.push_back({8'(mx), 7'(my), 3'b100});
          mdead = 1;
        end else begin
          exp_k = 4 + (SELF_COLLIDE ? mlen : 0);
          mdir = ed;
          if (geff) begin
            mlen++;
          end else begin
            exp_q.push_back({body.pop_front(), 3'b000});
          end
          exp_q.push_back({8'(nx), 7'(ny), 3'b010});
          body.push_back({8'(nx), 7'(ny)});
          mx = nx; my = ny;
          mgrow = 0;
        end
      end
    end
    dir = d;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    kl = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      tick = spam && (k == 1);
      @(negedge clk);
      if (!busy) begin
        kl = k;
        break;
      end
    end
    tick = 1'b0;
    check("busy_low_latency", kl, exp_k);
    @(posedge clk); #1;
    check("plots_drained", exp_q.size(), 0);
    check("length", length, mlen);
    check("dead", dead, mdead);
    $display("step dir=%02b grow=%0d head=(%0d,%0d) len=%0d dead=%0d", d, g, mx, my, mlen, mdead);
  endtask

  initial begin
    do_reset();

    do_step(2'b00, 0, 1);
    do_step(2'b00, 1, 0);
    do_step(2'b10, 0, 0);
    for (int i = 0; i < 6; i++) do_step(2'b01, 1, 0);
    do_step(2'b01, 1, 0);
    do_step(2'b11, 0, 0);
    do_step(2'b00, 0, 0);

    // Abandon a step mid-flight with reset; no plot may follow.
    dir = 2'b00;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    do_reset();

    for (int i = 0; i < 4; i++) do_step(2'b00, 1, 0);
    do_step(2'b01, 0, 0);
    do_step(2'b10, 0, 0);
    do_step(2'b11, 0, 0);
    do_step(2'b00, 0, 0);

    do_reset();
    for (int i = 0; i < 79; i++) do_step(2'b00, 0, 0);
    do_step(2'b00, 0, 0);
    do_step(2'b00, 0, 0);

    do_reset();
    for (int i = 0; i < 60; i++) do_step(2'b01, 0, 0);
    do_step(2'b01, 0, 0);
    do_step(2'b10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
